// File: rtl/keypad_scan_if.sv
// Keypad-side signal bundle: row sense in, column drive and debounced key result out.
interface keypad_scan_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key;
  logic       pressed;
  logic       key_valid;

  modport master (output row_in, input col_out, key, pressed, key_valid);
  modport slave  (input row_in, output col_out, key, pressed, key_valid);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner: column walk, row synchronizer, tick-based
// press/release debounce, registered key code with a one-cycle accept pulse.
module keypad_scan #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  keypad_scan_if.slave  kp
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_e;

  logic [3:0]       sync1_q, rs_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  state_e           state_q, state_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       col_out_q, col_out_d;
  logic [1:0]       cand_row_q, cand_row_d;
  logic [1:0]       cand_col_q, cand_col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       key_q, key_d;
  logic             pressed_q, pressed_d;
  logic             key_valid_q, key_valid_d;

  logic [1:0]       sample_row_c;
  logic             rows_idle_c;
  logic [CNT_W-1:0] cnt_inc_c;

  // Lowest-index low row wins when several rows are pressed together.
  always_comb begin
    sample_row_c = 2'd0;
    if (!rs_q[0])      sample_row_c = 2'd0;
    else if (!rs_q[1]) sample_row_c = 2'd1;
    else if (!rs_q[2]) sample_row_c = 2'd2;
    else if (!rs_q[3]) sample_row_c = 2'd3;
  end

  assign rows_idle_c = &rs_q;
  assign cnt_inc_c   = (cnt_q == CNT_DONE) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state and output logic; everything advances only on a scan tick.
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    cand_row_d  = cand_row_q;
    cand_col_d  = cand_col_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    pressed_d   = pressed_q;
    key_valid_d = 1'b0;
    div_d       = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    tick_d      = (div_q == DIV_LAST);

    case (state_q)
      ST_SCAN: begin
        if (tick_q) begin
          if (rows_idle_c) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            cand_row_d = sample_row_c;
            cand_col_d = col_idx_q;
            if (DEBOUNCE_SCANS == 1) begin
              key_d       = {sample_row_c, col_idx_q};
              pressed_d   = 1'b1;
              key_valid_d = 1'b1;
              cnt_d       = '0;
              state_d     = ST_HELD;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = ST_DEBOUNCE;
            end
          end
        end
      end

      ST_DEBOUNCE: begin
        if (tick_q) begin
          if (!rows_idle_c && (sample_row_c == cand_row_q)) begin
            if (cnt_inc_c == CNT_DONE) begin
              key_d       = {cand_row_q, cand_col_q};
              pressed_d   = 1'b1;
              key_valid_d = 1'b1;
              cnt_d       = '0;
              state_d     = ST_HELD;
            end else begin
              cnt_d = cnt_inc_c;
            end
          end else begin
            state_d   = ST_SCAN;
            col_idx_d = col_idx_q + 2'd1;
          end
        end
      end

      ST_HELD: begin
        // Column stays frozen; only the candidate row is watched for release.
        if (tick_q) begin
          if (rs_q[cand_row_q]) begin
            if (cnt_inc_c == CNT_DONE) begin
              pressed_d = 1'b0;
              cnt_d     = '0;
              state_d   = ST_SCAN;
              col_idx_d = col_idx_q + 2'd1;
            end else begin
              cnt_d = cnt_inc_c;
            end
          end else begin
            cnt_d = '0;
          end
        end
      end

      default: state_d = ST_SCAN;
    endcase

    col_out_d = ~(4'b0001 << col_idx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 4'hF;
      rs_q        <= 4'hF;
      div_q       <= '0;
      tick_q      <= 1'b0;
      state_q     <= ST_SCAN;
      col_idx_q   <= 2'd0;
      col_out_q   <= 4'b1110;
      cand_row_q  <= 2'd0;
      cand_col_q  <= 2'd0;
      cnt_q       <= '0;
      key_q       <= 4'd0;
      pressed_q   <= 1'b0;
      key_valid_q <= 1'b0;
    end else begin
      sync1_q     <= kp.row_in;
      rs_q        <= sync1_q;
      div_q       <= div_d;
      tick_q      <= tick_d;
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      col_out_q   <= col_out_d;
      cand_row_q  <= cand_row_d;
      cand_col_q  <= cand_col_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      pressed_q   <= pressed_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign kp.col_out   = col_out_q;
  assign kp.key       = key_q;
  assign kp.pressed   = pressed_q;
  assign kp.key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a key-matrix model drives the rows from the column
// drive, and a per-tick behavioural model predicts the debounced outputs.
module tb_keypad_scan;

  localparam int SD = 4;
  localparam int DS = 3;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] keys  = 16'h0000;
  int checks   = 0;
  int failures = 0;

  // Reference model state (scan position, candidate, streak, outputs).
  int         m_mode, m_col, m_row, m_ccol, m_streak;
  logic [3:0] m_key;
  logic       m_pr, m_kv;

  // Observed outputs right after an update edge, plus off-tick disturbances.
  logic [3:0] o_col, o_key;
  logic       o_pr, o_kv;
  int         o_extra;

  keypad_scan_if kif();

  function automatic logic [3:0] rows_for(input logic [15:0] k, input logic [3:0] cols);
    logic [3:0] r;
    r = 4'hF;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (k[ri*4+ci] && !cols[ci]) r[ri] = 1'b0;
    return r;
  endfunction

  function automatic logic [3:0] col_drive(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  function automatic int lowest_zero(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (!v[i]) return i;
    return 0;
  endfunction

  assign kif.row_in = rows_for(keys, kif.col_out);

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kif.slave)
  );

  always #5 clk = ~clk;

  task automatic model_reset;
    m_mode = 0; m_col = 0; m_row = 0; m_ccol = 0; m_streak = 0;
    m_key = 4'd0; m_pr = 1'b0; m_kv = 1'b0;
  endtask

  task automatic model_step;
    logic [3:0] rs;
    int low;
    rs  = rows_for(keys, col_drive(m_col));
    low = lowest_zero(rs);
    m_kv = 1'b0;
    case (m_mode)
      0: begin
        if (rs == 4'hF) m_col = (m_col + 1) % 4;
        else begin m_row = low; m_ccol = m_col; m_streak = 1; m_mode = 1; end
      end
      1: begin
        if (rs != 4'hF && low == m_row) begin
          m_streak++;
          if (m_streak == DS) begin
            m_key = 4'(m_row * 4 + m_ccol); m_pr = 1'b1; m_kv = 1'b1;
            m_streak = 0; m_mode = 2;
          end
        end else begin
          m_mode = 0; m_col = (m_col + 1) % 4;
        end
      end
      default: begin
        if (rs[m_row]) begin
          m_streak++;
          if (m_streak == DS) begin
            m_pr = 1'b0; m_mode = 0; m_col = (m_col + 1) % 4; m_streak = 0;
          end
        end else m_streak = 0;
      end
    endcase
  endtask

  // Consume one scan tick with the current key matrix, then apply nxt.
  task automatic run_tick(input logic [15:0] nxt);
    @(posedge clk);
    model_step();
    @(negedge clk);
    o_col = kif.col_out; o_key = kif.key; o_pr = kif.pressed; o_kv = kif.key_valid;
    keys = nxt;
    o_extra = 0;
    repeat (SD - 1) begin
      @(posedge clk);
      @(negedge clk);
      if (kif.key_valid !== 1'b0 || kif.col_out !== o_col ||
          kif.pressed !== o_pr || kif.key !== o_key) o_extra++;
    end
  endtask

  // Mid-cycle async reset pulse; outputs must drop before any clock edge.
  task automatic apply_reset_async(input string tag);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({kif.col_out, kif.key, kif.pressed, kif.key_valid} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL %s async_reset: got col=%b key=%0d pressed=%b valid=%b, want col=1110 key=0 pressed=0 valid=0",
               tag, kif.col_out, kif.key, kif.pressed, kif.key_valid);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (SD) @(posedge clk);
  endtask

  task automatic test_reset;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({kif.col_out, kif.key, kif.pressed, kif.key_valid} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values: got col=%b key=%0d pressed=%b valid=%b, want col=1110 key=0 pressed=0 valid=0",
               kif.col_out, kif.key, kif.pressed, kif.key_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (SD) @(posedge clk);
  endtask

  task automatic test_idle_scan;
    logic [3:0] exp_cols [4];
    exp_cols = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    for (int i = 0; i < 4; i++) begin
      run_tick(16'h0000);
      checks++;
      if (o_col !== exp_cols[i] || o_col !== col_drive(m_col) || o_extra != 0 || o_pr !== 1'b0) begin
        failures++;
        $display("FAIL idle_scan t%0d: got col=%b pressed=%b glitches=%0d, want col=%b pressed=0 glitches=0",
                 i, o_col, o_pr, o_extra, exp_cols[i]);
      end
    end
  endtask

  task automatic test_clean_press;
    int det, acc, n, pulses;
    det = -1; acc = -1; pulses = 0;
    run_tick(16'h0040);
    for (int i = 0; i < 12 && acc < 0; i++) begin
      run_tick(16'h0040);
      checks++;
      if ({o_col, o_key, o_pr, o_kv} !== {col_drive(m_col), m_key, m_pr, m_kv} || o_extra != 0) begin
        failures++;
        $display("FAIL press t%0d: got col=%b key=%0d pressed=%b valid=%b glitches=%0d, want col=%b key=%0d pressed=%b valid=%b",
                 i, o_col, o_key, o_pr, o_kv, o_extra, col_drive(m_col), m_key, m_pr, m_kv);
      end
      if (m_mode == 1 && det < 0) det = i;
      if (o_pr === 1'b1 && acc < 0) acc = i;
      pulses += int'(o_kv === 1'b1);
    end
    checks++;
    if (det < 0 || acc - det != DS - 1 || o_key !== 4'd6 || pulses != 1) begin
      failures++;
      $display("FAIL press_latency: got ticks=%0d key=%0d pulses=%0d, want ticks=%0d key=6 pulses=1",
               acc - det, o_key, pulses, DS - 1);
    end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      run_tick(16'h0040);
      pulses += int'(o_kv === 1'b1) + o_extra;
      if (o_pr !== 1'b1) pulses += 100;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL hold_no_repeat: got disturbances=%0d, want 0", pulses);
    end
    run_tick(16'h0000);
    n = 0; acc = -1;
    for (int i = 0; i < 8 && acc < 0; i++) begin
      run_tick(16'h0000);
      n++;
      checks++;
      if ({o_col, o_key, o_pr, o_kv} !== {col_drive(m_col), m_key, m_pr, m_kv} || o_extra != 0) begin
        failures++;
        $display("FAIL release t%0d: got col=%b key=%0d pressed=%b valid=%b glitches=%0d, want col=%b key=%0d pressed=%b valid=%b",
                 i, o_col, o_key, o_pr, o_kv, o_extra, col_drive(m_col), m_key, m_pr, m_kv);
      end
      if (o_pr === 1'b0) acc = i;
    end
    checks++;
    if (n != DS || o_col !== 4'b0111 || o_key !== 4'd6) begin
      failures++;
      $display("FAIL release_latency: got ticks=%0d col=%b key=%0d, want ticks=%0d col=0111 key=6",
               n, o_col, o_key, DS);
    end
  endtask

  task automatic test_bounce;
    int pulses;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      run_tick((i % 2 == 0) ? 16'h0001 : 16'h0000);
      checks++;
      if ({o_col, o_key, o_pr, o_kv} !== {col_drive(m_col), m_key, m_pr, m_kv} || o_extra != 0) begin
        failures++;
        $display("FAIL bounce t%0d: got col=%b key=%0d pressed=%b valid=%b glitches=%0d, want col=%b key=%0d pressed=%b valid=%b",
                 i, o_col, o_key, o_pr, o_kv, o_extra, col_drive(m_col), m_key, m_pr, m_kv);
      end
      pulses += int'(o_kv === 1'b1) + int'(o_pr !== 1'b0);
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL bounce_reject: got accepts=%0d, want 0", pulses);
    end
    for (int i = 0; i < 16 && o_pr !== 1'b1; i++) begin
      run_tick(16'h0001);
      pulses += int'(o_kv === 1'b1) + o_extra;
    end
    checks++;
    if (o_pr !== 1'b1 || o_key !== 4'd0 || pulses != 1) begin
      failures++;
      $display("FAIL bounce_stable: got pressed=%b key=%0d pulses=%0d, want pressed=1 key=0 pulses=1",
               o_pr, o_key, pulses);
    end
    for (int i = 0; i < 5; i++) run_tick(16'h0000);
  endtask

  task automatic test_simultaneous;
    int pulses;
    pulses = 0;
    for (int i = 0; i < 12 && o_pr !== 1'b1; i++) begin
      run_tick(16'h2020);
      checks++;
      if ({o_col, o_key, o_pr, o_kv} !== {col_drive(m_col), m_key, m_pr, m_kv} || o_extra != 0) begin
        failures++;
        $display("FAIL simul t%0d: got col=%b key=%0d pressed=%b valid=%b glitches=%0d, want col=%b key=%0d pressed=%b valid=%b",
                 i, o_col, o_key, o_pr, o_kv, o_extra, col_drive(m_col), m_key, m_pr, m_kv);
      end
    end
    checks++;
    if (o_pr !== 1'b1 || o_key !== 4'd5) begin
      failures++;
      $display("FAIL simul_key: got pressed=%b key=%0d, want pressed=1 key=5", o_pr, o_key);
    end
    for (int i = 0; i < 6; i++) begin
      run_tick(16'h2028);
      pulses += int'(o_kv === 1'b1) + o_extra + int'(o_pr !== 1'b1);
    end
    checks++;
    if (pulses != 0 || o_key !== 4'd5 || o_col !== 4'b1101) begin
      failures++;
      $display("FAIL simul_other_col: got key=%0d col=%b disturbances=%0d, want key=5 col=1101 disturbances=0",
               o_key, o_col, pulses);
    end
    for (int i = 0; i < 5; i++) run_tick(16'h0000);
  endtask

  task automatic test_reset_held;
    int acc;
    for (int i = 0; i < 16 && o_pr !== 1'b1; i++) run_tick(16'h0040);
    checks++;
    if (o_pr !== 1'b1 || o_key !== 4'd6) begin
      failures++;
      $display("FAIL held_before_reset: got pressed=%b key=%0d, want pressed=1 key=6", o_pr, o_key);
    end
    apply_reset_async("held");
    acc = -1;
    for (int i = 0; i < 10 && acc < 0; i++) begin
      run_tick(16'h0040);
      checks++;
      if ({o_col, o_key, o_pr, o_kv} !== {col_drive(m_col), m_key, m_pr, m_kv} || o_extra != 0) begin
        failures++;
        $display("FAIL requal t%0d: got col=%b key=%0d pressed=%b valid=%b glitches=%0d, want col=%b key=%0d pressed=%b valid=%b",
                 i, o_col, o_key, o_pr, o_kv, o_extra, col_drive(m_col), m_key, m_pr, m_kv);
      end
      if (o_pr === 1'b1) acc = i + 1;
    end
    // Columns 0,1 idle, detect on column 2 at tick 3, accept two ticks later.
    checks++;
    if (acc != 5 || o_key !== 4'd6 || o_kv !== 1'b1) begin
      failures++;
      $display("FAIL requal_timing: got tick=%0d key=%0d valid=%b, want tick=5 key=6 valid=1", acc, o_key, o_kv);
    end
    for (int i = 0; i < 5; i++) run_tick(16'h0000);
  endtask

  task automatic test_random;
    int r, hold;
    logic [15:0] k, kk;
    for (int it = 0; it < 40; it++) begin
      r = int'($urandom_range(0, 3));
      case (r)
        0:       k = 16'h0000;
        1:       k = 16'h0001 << $urandom_range(0, 15);
        2:       k = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
        default: k = 16'h0001 << $urandom_range(0, 15);
      endcase
      hold = int'($urandom_range(1, 10));
      for (int h = 0; h < hold; h++) begin
        kk = (r == 3 && (h % 2) == 1) ? 16'h0000 : k;
        run_tick(kk);
        checks++;
        if ({o_col, o_key, o_pr, o_kv} !== {col_drive(m_col), m_key, m_pr, m_kv} || o_extra != 0) begin
          failures++;
          $display("FAIL random it%0d h%0d: got col=%b key=%0d pressed=%b valid=%b glitches=%0d, want col=%b key=%0d pressed=%b valid=%b",
                   it, h, o_col, o_key, o_pr, o_kv, o_extra, col_drive(m_col), m_key, m_pr, m_kv);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_held();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
